// File: rtl/arm_mem_resp.sv
// -----------------------------------------------------------------------------
// arm_mem_resp
// Single-port memory responder for an ARM-style core: it serves instruction
// fetches, data loads and data stores from one internal word array, one
// access at a time, with a programmable number of wait states.
//
// Optional feature macro: ARM_MEM_RANGE_CHECK_EN
//   Undefined (default): upper address bits are ignored and addresses wrap.
//   Defined: adds output mem_err. An access with any upper address bit set
//            completes with normal timing and raises mem_err with its strobe.
//            Such a load or fetch returns 0, and such a store leaves the array
//            unchanged.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-low reset
//   inst_addr       [29:0] fetch word address
//   inst_req        fetch request (level, held until inst_valid)
//   inst            [31:0] fetched word (holds until the next fetch response)
//   inst_valid      one-cycle fetch-complete strobe
//   mem_addr        [29:0] data word address
//   mem_rd_req      load request (level, held until mem_data_valid)
//   mem_wr_req      store request (level, held until mem_wr_ack)
//   mem_data_in     [31:0] store data
//   mem_data_out    [31:0] load data (holds until the next load response)
//   mem_data_valid  one-cycle load-complete strobe
//   mem_wr_ack      one-cycle store-complete strobe
//   busy            high while the FSM is not idle
//   mem_err         (macro only) out-of-range flag, valid with the strobe
// -----------------------------------------------------------------------------
module arm_mem_resp #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] inst_addr,
  input  logic        inst_req,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic [29:0] mem_addr,
  input  logic        mem_rd_req,
  input  logic        mem_wr_req,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_data_out,
  output logic        mem_data_valid,
  output logic        mem_wr_ack,
`ifdef ARM_MEM_RANGE_CHECK_EN
  output logic        mem_err,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {T_WR = 2'd0, T_RD = 2'd1, T_IF = 2'd2} acc_t;

  // The accepting edge only latches the request. The WAIT stretch then covers
  // the latch cycle plus WAIT_STATES cycles, so the strobe arrives in the cycle
  // after edge k+WAIT_STATES+1. With WAIT_STATES=0 the WAIT stretch is exactly
  // one cycle.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t               r_state;
  state_t               w_next_state;
  logic [3:0]           r_cnt;
  logic [3:0]           w_next_cnt;
  acc_t                 r_type;
  acc_t                 w_sel_type;
  logic                 w_accept;
  logic [29:0]          w_sel_addr;
  logic                 w_sel_oor;
  logic [ADDR_BITS-1:0] r_addr;
  logic [31:0]          r_wdata;
  logic                 r_oor;
  logic                 w_enter_done;
  logic [31:0]          w_rdata;
  logic [31:0]          r_mem [0:(1<<ADDR_BITS)-1];

`ifdef ARM_MEM_RANGE_CHECK_EN
  assign w_sel_oor = |w_sel_addr[29:ADDR_BITS];
`else
  // Upper address bits are dropped, so the array index wraps.
  logic w_unused_hi;
  assign w_sel_oor   = 1'b0;
  assign w_unused_hi = ^w_sel_addr[29:ADDR_BITS];
`endif

  // Fixed-priority request select: store > load > fetch.
  always_comb begin
    w_accept   = 1'b0;
    w_sel_type = T_IF;
    w_sel_addr = inst_addr;
    if (mem_wr_req) begin
      w_accept   = 1'b1;
      w_sel_type = T_WR;
      w_sel_addr = mem_addr;
    end else if (mem_rd_req) begin
      w_accept   = 1'b1;
      w_sel_type = T_RD;
      w_sel_addr = mem_addr;
    end else if (inst_req) begin
      w_accept   = 1'b1;
      w_sel_type = T_IF;
      w_sel_addr = inst_addr;
    end else begin
      w_accept   = 1'b0;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_WAIT;
          w_next_cnt   = WAIT_LOAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S_DONE;
        end else begin
          w_next_cnt   = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 4'd0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // The edge that moves WAIT into DONE performs the array access. The state is
  // cleared asynchronously by reset, so a reset before this edge blocks the write.
  assign w_enter_done = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_rdata      = r_oor ? 32'd0 : r_mem[r_addr];

  // Backing store write port; the array contents are not reset.
  always_ff @(posedge clk) begin
    if (w_enter_done && (r_type == T_WR) && !r_oor) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_type         <= T_IF;
      r_addr         <= '0;
      r_wdata        <= 32'd0;
      r_oor          <= 1'b0;
      inst           <= 32'd0;
      inst_valid     <= 1'b0;
      mem_data_out   <= 32'd0;
      mem_data_valid <= 1'b0;
      mem_wr_ack     <= 1'b0;
      busy           <= 1'b0;
`ifdef ARM_MEM_RANGE_CHECK_EN
      mem_err        <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if ((r_state == S_IDLE) && w_accept) begin
        r_type  <= w_sel_type;
        r_addr  <= w_sel_addr[ADDR_BITS-1:0];
        r_wdata <= mem_data_in;
        r_oor   <= w_sel_oor;
      end
      if (w_enter_done && (r_type == T_IF)) begin
        inst <= w_rdata;
      end
      if (w_enter_done && (r_type == T_RD)) begin
        mem_data_out <= w_rdata;
      end
      inst_valid     <= w_enter_done && (r_type == T_IF);
      mem_data_valid <= w_enter_done && (r_type == T_RD);
      mem_wr_ack     <= w_enter_done && (r_type == T_WR);
      busy           <= (w_next_state != S_IDLE);
`ifdef ARM_MEM_RANGE_CHECK_EN
      mem_err        <= w_enter_done && r_oor;
`endif
    end
  end

endmodule

// File: tb/tb_arm_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_arm_mem_resp
// Directed, self-checking bench for arm_mem_resp. It drives two instances:
//   u_dut  : WAIT_STATES=1
//   u_dut0 : WAIT_STATES=0
// Checks cover reset values, store/load/fetch latency and data, request
// priority, back-to-back fetches, reset during an access, and address
// wrap/range behaviour. Define ARM_MEM_RANGE_CHECK_EN to exercise mem_err.
// -----------------------------------------------------------------------------
module tb_arm_mem_resp;

  logic        clk;
  logic        rst;
  logic [29:0] inst_addr;
  logic        inst_req;
  logic [31:0] inst;
  logic        inst_valid;
  logic [29:0] mem_addr;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_data_valid;
  logic        mem_wr_ack;
  logic        busy;
  logic        mem_err;

  logic [29:0] z_inst_addr;
  logic        z_inst_req;
  logic [31:0] z_inst;
  logic        z_inst_valid;
  logic [29:0] z_mem_addr;
  logic        z_mem_rd_req;
  logic        z_mem_wr_req;
  logic [31:0] z_mem_data_in;
  logic [31:0] z_mem_data_out;
  logic        z_mem_data_valid;
  logic        z_mem_wr_ack;
  logic        z_busy;
  logic        z_mem_err;

  int checks = 0;
  int errors = 0;

  arm_mem_resp #(.ADDR_BITS(10), .WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_req(inst_req), .inst(inst), .inst_valid(inst_valid),
    .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_data_valid(mem_data_valid), .mem_wr_ack(mem_wr_ack),
`ifdef ARM_MEM_RANGE_CHECK_EN
    .mem_err(mem_err),
`endif
    .busy(busy)
  );

  arm_mem_resp #(.ADDR_BITS(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .inst_addr(z_inst_addr), .inst_req(z_inst_req), .inst(z_inst), .inst_valid(z_inst_valid),
    .mem_addr(z_mem_addr), .mem_rd_req(z_mem_rd_req), .mem_wr_req(z_mem_wr_req),
    .mem_data_in(z_mem_data_in), .mem_data_out(z_mem_data_out),
    .mem_data_valid(z_mem_data_valid), .mem_wr_ack(z_mem_wr_ack),
`ifdef ARM_MEM_RANGE_CHECK_EN
    .mem_err(z_mem_err),
`endif
    .busy(z_busy)
  );

`ifndef ARM_MEM_RANGE_CHECK_EN
  assign mem_err   = 1'b0;
  assign z_mem_err = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on u_dut: kind 0=store, 1=load, 2=fetch. The request is dropped
  // in the strobe cycle. lat counts edges from the raise to the strobe cycle.
  task automatic acc_a(input int kind, input logic [29:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic er);
    logic got;
    got = 1'b0;
    lat = 0;
    case (kind)
      0:       begin mem_wr_req = 1'b1; mem_addr = a; mem_data_in = d; end
      1:       begin mem_rd_req = 1'b1; mem_addr = a; end
      default: begin inst_req = 1'b1; inst_addr = a; end
    endcase
    while (!got && lat < 20) begin
      step();
      lat++;
      got = (kind == 0) ? mem_wr_ack : ((kind == 1) ? mem_data_valid : inst_valid);
    end
    rd = (kind == 2) ? inst : mem_data_out;
    er = mem_err;
    mem_wr_req = 1'b0;
    mem_rd_req = 1'b0;
    inst_req   = 1'b0;
    step();
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          t_d;
    int          t_i;
    int          v1;
    int          v2;
    int          lowcnt;
    logic        got;

    inst_addr = 30'd0; inst_req = 1'b0; mem_addr = 30'd0; mem_rd_req = 1'b0;
    mem_wr_req = 1'b0; mem_data_in = 32'd0;
    z_inst_addr = 30'd0; z_inst_req = 1'b0; z_mem_addr = 30'd0; z_mem_rd_req = 1'b0;
    z_mem_wr_req = 1'b0; z_mem_data_in = 32'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(mem_wr_ack), 32'd0);
    chk("rst_dvalid", 32'(mem_data_valid), 32'd0);
    chk("rst_ivalid", 32'(inst_valid), 32'd0);
    chk("rst_dout", mem_data_out, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_z_busy", 32'(z_busy), 32'd0);
    rst = 1'b1;
    step();

    // Preloads, then store/load of 0xDEADBEEF at 0x004.
    acc_a(0, 30'h010, 32'hCAFEF00D, lat, rd, er);
    acc_a(0, 30'h000, 32'h11111111, lat, rd, er);
    acc_a(0, 30'h004, 32'hDEADBEEF, lat, rd, er);
    chk("store_lat", 32'(lat), 32'd3);
    acc_a(1, 30'h004, 32'd0, lat, rd, er);
    chk("load_lat", 32'(lat), 32'd3);
    chk("load_data", rd, 32'hDEADBEEF);
    chk("load_strobe_1cyc", 32'(mem_data_valid), 32'd0);
    chk("load_hold", mem_data_out, 32'hDEADBEEF);

    // Load and fetch raised together: load first, fetch 4 cycles after.
    mem_addr = 30'h010; inst_addr = 30'h004;
    mem_rd_req = 1'b1; inst_req = 1'b1;
    t_d = -1; t_i = -1;
    for (int c = 1; c <= 20 && t_i < 0; c++) begin
      step();
      if (mem_data_valid) begin t_d = c; mem_rd_req = 1'b0; end
      if (inst_valid)     begin t_i = c; inst_req = 1'b0; end
    end
    inst_req = 1'b0; mem_rd_req = 1'b0;
    chk("prio_load_cycle", 32'(t_d), 32'd3);
    chk("prio_fetch_gap", 32'(t_i - t_d), 32'd4);
    chk("prio_fetch_data", inst, 32'hDEADBEEF);
    chk("prio_dout_hold", mem_data_out, 32'hCAFEF00D);
    step();

    // WAIT_STATES=0: preload two words, then back-to-back fetches.
    for (int n = 0; n < 2; n++) begin
      z_mem_addr = 30'(n); z_mem_data_in = 32'h50000000 + 32'(n); z_mem_wr_req = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        step();
        if (z_mem_wr_ack) begin got = 1'b1; z_mem_wr_req = 1'b0; end
      end
      z_mem_wr_req = 1'b0;
      chk("z_store_ack", 32'(got), 32'd1);
      step();
    end
    z_inst_addr = 30'h000; z_inst_req = 1'b1;
    v1 = -1; v2 = -1; lowcnt = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (z_inst_valid) begin
        if (v1 < 0) begin
          v1 = c;
          chk("z_fetch0_data", z_inst, 32'h50000000);
          z_inst_addr = 30'h001;
        end else if (v2 < 0) begin
          v2 = c;
          chk("z_fetch1_data", z_inst, 32'h50000001);
          z_inst_req = 1'b0;
        end
      end else if (v1 >= 0 && v2 < 0 && !z_busy) begin
        lowcnt++;
      end
    end
    z_inst_req = 1'b0;
    chk("z_first_valid", 32'(v1), 32'd2);
    chk("z_valid_period", 32'(v2 - v1), 32'd3);
    chk("z_busy_low", 32'(lowcnt), 32'd1);

    // Reset pulse during WAIT of a store to 0x010.
    mem_wr_req = 1'b1; mem_addr = 30'h010; mem_data_in = 32'h12345678;
    step();
    chk("abort_busy_wait", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dout", mem_data_out, 32'd0);
    chk("abort_inst", inst, 32'd0);
    step();
    chk("abort_no_ack", 32'(mem_wr_ack), 32'd0);
    mem_wr_req = 1'b0;
    step();
    chk("abort_no_ack2", 32'(mem_wr_ack), 32'd0);
    rst = 1'b1;
    step();
    acc_a(1, 30'h010, 32'd0, lat, rd, er);
    chk("abort_lat", 32'(lat), 32'd3);
    chk("abort_prior", rd, 32'hCAFEF00D);

    // Address beyond the array.
    acc_a(0, 30'h400, 32'h0BADF00D, lat, rd, er);
    chk("oor_store_lat", 32'(lat), 32'd3);
`ifdef ARM_MEM_RANGE_CHECK_EN
    chk("oor_store_err", 32'(er), 32'd1);
    acc_a(1, 30'h000, 32'd0, lat, rd, er);
    chk("oor_word0", rd, 32'h11111111);
    chk("oor_word0_err", 32'(er), 32'd0);
    acc_a(1, 30'h400, 32'd0, lat, rd, er);
    chk("oor_load_zero", rd, 32'd0);
    chk("oor_load_err", 32'(er), 32'd1);
`else
    acc_a(1, 30'h000, 32'd0, lat, rd, er);
    chk("wrap_word0", rd, 32'h0BADF00D);
    acc_a(2, 30'h404, 32'd0, lat, rd, er);
    chk("wrap_fetch_lat", 32'(lat), 32'd3);
    chk("wrap_fetch", rd, 32'hDEADBEEF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
